// File: rtl/hkspi_pkg.sv
// Shared opcodes, byte selectors and FSM states for the
// housekeeping-SPI stream master.
package hkspi_pkg;

  localparam logic [7:0] HKSPI_CMD_WRITE_STREAM = 8'h80;
  localparam logic [7:0] HKSPI_CMD_READ_STREAM  = 8'h40;
  localparam logic [7:0] HKSPI_CMD_NOP          = 8'h00;

  localparam logic [1:0] SEL_OP   = 2'd0;
  localparam logic [1:0] SEL_ADDR = 2'd1;
  localparam logic [1:0] SEL_DATA = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_LOAD,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_BYTE_END,
    ST_CS_HOLD,
    ST_CS_GAP
  } hkspi_state_e;

endpackage

// File: rtl/hkspi_byte_shifter.sv
// One SPI byte, MSB first: SCK phase divider, bit counter,
// TX/RX shift registers. SDO is sampled on the last low-phase cycle.
module hkspi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       sdo_i,
  output logic       sck_o,
  output logic       sdi_o,
  output logic       lo_done_o,
  output logic       bit_done_o,
  output logic       byte_done_o,
  output logic [7:0] rx_o
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic             active_q;
  logic             phase_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;
  logic             div_end;

  assign div_end     = active_q && (div_q == DIV_MAX);
  assign lo_done_o   = div_end && !phase_q;
  assign bit_done_o  = div_end && phase_q;
  assign byte_done_o = bit_done_o && (bit_q == 3'd7);
  assign sck_o       = phase_q;
  assign sdi_o       = tx_q[7];
  assign rx_o        = rx_q;

  // tx shifts after every bit, so it is empty (SDI=0) between bytes
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      div_q    <= '0;
      bit_q    <= 3'd0;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
    end else if (load_i) begin
      active_q <= 1'b1;
      phase_q  <= 1'b0;
      div_q    <= '0;
      bit_q    <= 3'd0;
      tx_q     <= data_i;
    end else if (active_q) begin
      if (div_end) begin
        div_q   <= '0;
        phase_q <= !phase_q;
        if (!phase_q) begin
          rx_q <= {rx_q[6:0], sdo_i};
        end else begin
          tx_q  <= {tx_q[6:0], 1'b0};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) active_q <= 1'b0;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hkspi_stream_master.sv
// Housekeeping-SPI stream master: opcode, address, then N data
// bytes, with valid/ready streams for write and read data.
module hkspi_stream_master
  import hkspi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 5
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic             spi_sck,
  output logic             spi_csb,
  output logic             spi_sdi,
  input  logic             spi_sdo
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  hkspi_state_e     state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [7:0]       addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] dcnt_q, dcnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             csb_q, csb_d;
  logic             rdv_q, rdv_d;
  logic [7:0]       rdd_q, rdd_d;
  logic             done_q, done_d;

  logic       load;
  logic [7:0] tx_byte;
  logic       lo_done;
  logic       bit_done;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic       is_data;
  logic       data_left;

  assign is_data   = (sel_q == SEL_DATA);
  assign data_left = (dcnt_q != len_q);

  hkspi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk_i       (clock),
    .rst_ni      (resetb),
    .load_i      (load),
    .data_i      (tx_byte),
    .sdo_i       (spi_sdo),
    .sck_o       (spi_sck),
    .sdi_o       (spi_sdi),
    .lo_done_o   (lo_done),
    .bit_done_o  (bit_done),
    .byte_done_o (byte_done),
    .rx_o        (rx_byte)
  );

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= 8'h00;
      len_q   <= '0;
      dcnt_q  <= '0;
      sel_q   <= SEL_OP;
      csb_q   <= 1'b1;
      rdv_q   <= 1'b0;
      rdd_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      dcnt_q  <= dcnt_d;
      sel_q   <= sel_d;
      csb_q   <= csb_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    sel_d   = sel_q;
    csb_d   = csb_q;
    rdv_d   = rdv_q;
    rdd_d   = rdd_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_CS_SETUP;
          cnt_d   = '0;
          write_d = cmd_write;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          dcnt_d  = '0;
          sel_d   = SEL_OP;
          csb_d   = 1'b0;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == DIV_MAX) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        if (is_data && !data_left) begin
          cnt_d   = '0;
          state_d = ST_CS_HOLD;
        end else if (!(is_data && write_q && !wr_valid)) begin
          load    = 1'b1;
          state_d = ST_BIT_LO;
        end
      end
      ST_BIT_LO: begin
        if (lo_done) state_d = ST_BIT_HI;
      end
      ST_BIT_HI: begin
        if (byte_done) begin
          state_d = ST_BYTE_END;
          if (is_data && !write_q) begin
            rdv_d = 1'b1;
            rdd_d = rx_byte;
          end
        end else if (bit_done) begin
          state_d = ST_BIT_LO;
        end
      end
      ST_BYTE_END: begin
        if (!rdv_q || rd_ready) begin
          rdv_d   = 1'b0;
          state_d = ST_LOAD;
          if (is_data) dcnt_d = dcnt_q + 1'b1;
          else         sel_d  = sel_q + 2'd1;
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == DIV_MAX) begin
          cnt_d   = '0;
          csb_d   = 1'b1;
          state_d = ST_CS_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CS_GAP: begin
        if (cnt_q == DIV_MAX) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    wr_ready  = (state_q == ST_LOAD) && is_data && write_q
                && data_left && wr_valid;
    unique case (sel_q)
      SEL_OP:   tx_byte = write_q ? HKSPI_CMD_WRITE_STREAM
                                  : HKSPI_CMD_READ_STREAM;
      SEL_ADDR: tx_byte = addr_q;
      default:  tx_byte = write_q ? wr_data : HKSPI_CMD_NOP;
    endcase
  end

  assign rd_valid = rdv_q;
  assign rd_data  = rdd_q;
  assign done     = done_q;
  assign spi_csb  = csb_q;

endmodule

// File: doc/hkspi_stream_master.md
Name: hkspi_stream_master

Overview:
Synthesizable SPI master that issues housekeeping-SPI stream transactions. It sits directly upstream of the housekeeping SPI slave, driving the SCK, CSB and SDI pins and sampling SDO. A test-harness or management core issues a command: write/read, register address and byte count. The block generates the command byte (0x80 for write stream, 0x40 for read stream), the address byte, then N data bytes, MSB first. Write data and read data travel over valid/ready streams.

Parameters:
CLK_DIV, 4, clock cycles per SCK half-period (≥2); also the CSB setup, hold and min-high time
LEN_W, 5, width of cmd_len; up to 2^LEN_W-1 data bytes per transaction

Ports:
clock  in  1  system clock
resetb  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write stream (0x80), 0 = read stream (0x40)
cmd_addr  in  8  start register address
cmd_len  in  LEN_W  data byte count; 0 = command and address bytes only
wr_valid  in  1  write byte available
wr_ready  out  1  write byte accepted (1-cycle pulse)
wr_data  in  8  write byte
rd_valid  out  1  read byte held until accepted
rd_ready  in  1  consumer accepts read byte
rd_data  out  8  read byte
busy  out  1  transaction in progress (CSB low or CSB-high guard time)
done  out  1  1-cycle pulse when CSB returns high
spi_sck  out  1  SPI clock, idle low
spi_csb  out  1  chip select, active low
spi_sdi  out  1  master-out data
spi_sdo  in  1  master-in data

Behaviour:
- Reset (resetb low at a clock edge): state IDLE; spi_csb=1, spi_sck=0, spi_sdi=0; cmd_ready=1 after reset; wr_ready, rd_valid, done and busy = 0; rd_data = 0. A reset mid-transaction aborts immediately. CSB goes high on the next edge and no done pulse is issued.
- Handshake: a command is captured on the cycle where cmd_valid and cmd_ready are both 1. The captured fields are held until done.
- State machine:
  - IDLE: on accept, drive CSB low and go to CS_SETUP.
  - CS_SETUP: wait CLK_DIV cycles, then go to LOAD.
  - LOAD: select the byte to send. Byte 0 is the opcode and byte 1 is cmd_addr. For write data bytes, wait in LOAD until wr_valid; on that cycle pulse wr_ready and latch wr_data. Read data bytes shift out 0x00. If the byte count is exhausted, go to CS_HOLD.
  - BIT_LO: SCK low for CLK_DIV cycles. SDI is updated on entry. SDO is sampled on the last cycle of the phase, just before the rising edge.
  - BIT_HI: SCK high for CLK_DIV cycles. After 8 bits, go to BYTE_END; otherwise go to BIT_LO.
  - BYTE_END: for read data bytes, present rd_data and rd_valid, and stall with SCK low until rd_ready. Then go to LOAD.
  - CS_HOLD: SCK low for CLK_DIV cycles, then CSB high and go to CS_GAP.
  - CS_GAP: CSB high for CLK_DIV cycles, then pulse done and go to IDLE.
- Stalls (wr_valid low, or rd_ready low) always occur with SCK low and CSB low. An unbounded stall is legal.
- Bit order is MSB first. A 3-bit bit counter and a LEN_W-bit byte counter are used; the byte counter never wraps because it is compared against cmd_len.
- SDI is a don't-care during read data bytes and is driven to 0.
- Total SCK rising edges per transaction = 8 × (2 + cmd_len).

Decomposition:
- Package hkspi_pkg holds:
  - HKSPI_CMD_WRITE_STREAM = 8'h80
  - HKSPI_CMD_READ_STREAM = 8'h40
  - HKSPI_CMD_NOP = 8'h00
  - the state enum
- Sub-module hkspi_byte_shifter: an 8-bit shift register plus bit counter and SCK phase divider. It has load/start, bit_done and byte_done outputs. The parent FSM owns CSB, the byte sequencing and the streams.

Test Plan:
- Read, CLK_DIV=4, slave model returns 0x20 at reg 3: cmd read, addr 0x03, len 1 -> SDI bytes 0x40, 0x03; rd_data=0x20 with one rd_valid; 24 SCK rising edges; done pulse once.
- Write: cmd write, addr 0x0b, len 1, wr_data 0x01 -> SDI bytes 0x80, 0x0b, 0x01; exactly one wr_ready pulse; slave reg 0x0b = 0x01.
- Stream read, addr 0x00, len 19 -> 19 rd_valid beats in order matching the slave model (reg1=0x04, reg2=0x56, reg13=0xff, reg14=0xef, reg18=0x04); CSB stays low throughout.
- Backpressure: hold wr_valid low for 50 cycles before the data byte, and rd_ready low for 30 cycles -> SCK frozen low and CSB low for the whole stall; transferred data is unchanged.
- len=0, addr 0x05 -> exactly 16 SCK edges, no wr_ready or rd_valid, done pulses.
- Reset mid-transfer: assert resetb low during bit 3 of the address byte -> next edge gives csb=1, sck=0, cmd_ready=1, no done; a following read of reg 3 returns 0x20.
